// File: rtl/sprite_pixel_gen.sv
// Per-pixel sprite overlay stage: hit test, ROM addressing and transparency merge,
// with a one-entry position buffer that commits only on frame_tick.
module sprite_pixel_gen #(
   parameter int          SPRITE_W  = 16,
   parameter int          SPRITE_H  = 16,
   parameter int          ROW_BITS  = 4,
   parameter int          COL_BITS  = 4,
   parameter logic [11:0] KEY_COLOR = 12'hF0F,
   parameter logic [11:0] BG_COLOR  = 12'h000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   input  logic                video_on,
   input  logic                frame_tick,
   input  logic                enable,
   input  logic [9:0]          pos_x,
   input  logic [9:0]          pos_y,
   input  logic                pos_valid,
   output logic                pos_ready,
   output logic [ROW_BITS-1:0] rom_row,
   output logic [COL_BITS-1:0] rom_col,
   input  logic [11:0]         rom_data,
   output logic [11:0]         rgb,
   output logic                rgb_valid,
   output logic                sprite_hit
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   localparam logic [10:0] W_SPAN = 11'(SPRITE_W);
   localparam logic [10:0] H_SPAN = 11'(SPRITE_H);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_load_pend;
   logic        w_commit;
   logic [9:0]  r_cur_x;
   logic [9:0]  r_cur_y;
   logic [9:0]  r_pend_x;
   logic [9:0]  r_pend_y;
   logic        r_hit1;
   logic        r_von1;
   logic [11:0] r_rgb;
   logic        r_rgb_valid;
   logic        r_sprite_hit;
   logic [10:0] w_x_end;
   logic [10:0] w_y_end;
   logic        w_hit0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_pend = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_EMPTY: if (pos_valid) begin
            w_load_pend = 1'b1;
            w_state_nxt = S_FULL;
         end
         S_FULL: if (frame_tick) begin
            w_commit    = 1'b1;
            w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   assign pos_ready = (r_state == S_EMPTY);

   // pend contents are only meaningful while FULL, so they need no reset
   always_ff @(posedge clk) begin
      if (w_load_pend) begin
         r_pend_x <= pos_x;
         r_pend_y <= pos_y;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_x <= '0;
         r_cur_y <= '0;
      end else if (w_commit) begin
         r_cur_x <= r_pend_x;
         r_cur_y <= r_pend_y;
      end
   end

   // 11-bit bounds so a sprite near 1023 never wraps onto column/row 0
   assign w_x_end = {1'b0, r_cur_x} + W_SPAN;
   assign w_y_end = {1'b0, r_cur_y} + H_SPAN;
   assign w_hit0  = enable & video_on
                  & ({1'b0, x} >= {1'b0, r_cur_x}) & ({1'b0, x} < w_x_end)
                  & ({1'b0, y} >= {1'b0, r_cur_y}) & ({1'b0, y} < w_y_end);

   assign rom_col = x[COL_BITS-1:0] - r_cur_x[COL_BITS-1:0];
   assign rom_row = y[ROW_BITS-1:0] - r_cur_y[ROW_BITS-1:0];

   // stage 1: align hit/video_on with the ROM's registered read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit1 <= 1'b0;
         r_von1 <= 1'b0;
      end else begin
         r_hit1 <= w_hit0;
         r_von1 <= video_on;
      end
   end

   // stage 2: colour merge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgb        <= 12'h000;
         r_rgb_valid  <= 1'b0;
         r_sprite_hit <= 1'b0;
      end else begin
         r_rgb_valid <= r_von1;
         if (!r_von1) begin
            r_rgb        <= 12'h000;
            r_sprite_hit <= 1'b0;
         end else if (r_hit1 && (rom_data != KEY_COLOR)) begin
            r_rgb        <= rom_data;
            r_sprite_hit <= 1'b1;
         end else begin
            r_rgb        <= BG_COLOR;
            r_sprite_hit <= 1'b0;
         end
      end
   end

   assign rgb        = r_rgb;
   assign rgb_valid  = r_rgb_valid;
   assign sprite_hit = r_sprite_hit;

endmodule
